// File: rtl/conv_pkg.sv
// Shared types, fixed kernel tables and the output-fit helper for the 3x3 convolution engine.
package conv_pkg;

  localparam int unsigned NTAPS = 9;
  localparam int unsigned KC_W  = 4;
  localparam int unsigned FIT_W = 64;

  typedef enum logic [1:0] {
    MODE_PROG  = 2'd0,
    MODE_SOBX  = 2'd1,
    MODE_SOBY  = 2'd2,
    MODE_IDENT = 2'd3
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ROW0,
    ST_ROW1,
    ST_ROW2,
    ST_DONE
  } state_e;

  // Taps packed p8..p0 (p0 in LSBs), 4-bit two's complement.
  localparam logic [NTAPS-1:0][KC_W-1:0] SOBX_K  = 36'hF01E02F01;
  localparam logic [NTAPS-1:0][KC_W-1:0] SOBY_K  = 36'hFEF000121;
  localparam logic [NTAPS-1:0][KC_W-1:0] IDENT_K = 36'h000010000;

  // Returns {sat, value}; value holds the fitted result sign-extended to FIT_W.
  function automatic logic [FIT_W:0] sat_fit(input logic signed [FIT_W-1:0] acc,
                                             input int unsigned out_w,
                                             input logic sat_en);
    logic signed [FIT_W-1:0] hi;
    logic signed [FIT_W-1:0] lo;
    logic signed [FIT_W-1:0] wrapped;
    logic signed [FIT_W-1:0] value;
    logic sat;
    hi      = (64'sd1 <<< (out_w - 32'd1)) - 64'sd1;
    lo      = ~hi;
    wrapped = (acc <<< (FIT_W - out_w)) >>> (FIT_W - out_w);
    if (sat_en) begin
      sat   = (acc > hi) || (acc < lo);
      value = (acc > hi) ? hi : ((acc < lo) ? lo : acc);
    end else begin
      sat   = (wrapped != acc);
      value = wrapped;
    end
    return {sat, value};
  endfunction

endpackage

// File: rtl/conv3_row_mac.sv
// Combinational 3-tap signed dot product: three pixels times three weights, summed at ACC_W.
module conv3_row_mac
  import conv_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned COEF_W = 8,
  parameter int unsigned ACC_W  = 20
) (
  input  logic [3*DATA_W-1:0]     i_pix,
  input  logic [3*COEF_W-1:0]     i_wgt,
  output logic signed [ACC_W-1:0] o_sum_c
);

  localparam int unsigned PROD_W = DATA_W + COEF_W;

  logic signed [PROD_W-1:0] w_prod [3];

  always_comb begin
    o_sum_c = '0;
    for (int unsigned k = 0; k < 3; k++) begin
      w_prod[k] = PROD_W'($signed(i_pix[k*DATA_W +: DATA_W]))
                * PROD_W'($signed(i_wgt[k*COEF_W +: COEF_W]));
      o_sum_c   = o_sum_c + ACC_W'(w_prod[k]);
    end
  end

endmodule

// File: rtl/conv3x3_mc_engine.sv
// Multicycle 3x3 convolution: one kernel row per cycle, bias add, saturate or wrap to OUT_W.
module conv3x3_mc_engine
  import conv_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned COEF_W = 8,
  parameter int unsigned ACC_W  = 20,
  parameter int unsigned OUT_W  = 16,
  parameter bit          SAT_EN = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [9*DATA_W-1:0]   in_win,
  input  logic [1:0]            mode_sel,
  input  logic [OUT_W-1:0]      cfg_bias,
  input  logic                  wgt_wr_en,
  input  logic [3:0]            wgt_addr,
  input  logic [COEF_W-1:0]     wgt_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_W-1:0]      out_data,
  output logic                  out_sat
);

  state_e                          r_state;
  state_e                          w_next;
  logic [9*DATA_W-1:0]             r_win;
  logic signed [OUT_W-1:0]         r_bias;
  logic signed [ACC_W-1:0]         r_acc;
  logic signed [ACC_W-1:0]         w_row_sum;
  logic signed [ACC_W-1:0]         w_final;
  logic [NTAPS-1:0][COEF_W-1:0]    r_shadow;
  logic [NTAPS-1:0][COEF_W-1:0]    r_active;
  logic [NTAPS-1:0][COEF_W-1:0]    w_kernel;
  logic [3*DATA_W-1:0]             w_row_pix;
  logic [3*COEF_W-1:0]             w_row_wgt;
  logic [FIT_W:0]                  w_fit;
  logic                            w_accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // in_ready is combinational from out_ready so a drain and an accept can share an edge.
  always_comb begin
    w_next   = r_state;
    in_ready = 1'b0;
    case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next = ST_ROW0;
      end
      ST_ROW0: w_next = ST_ROW1;
      ST_ROW1: w_next = ST_ROW2;
      ST_ROW2: w_next = ST_DONE;
      ST_DONE: begin
        if (out_ready) begin
          in_ready = 1'b1;
          w_next   = in_valid ? ST_ROW0 : ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  assign w_accept = in_valid && in_ready;

  // Kernel latched at accept; a same-cycle shadow write forwards into the programmable copy.
  always_comb begin
    w_kernel = r_shadow;
    for (int unsigned i = 0; i < NTAPS; i++) begin
      case (mode_e'(mode_sel))
        MODE_SOBX:  w_kernel[i] = COEF_W'($signed(SOBX_K[i]));
        MODE_SOBY:  w_kernel[i] = COEF_W'($signed(SOBY_K[i]));
        MODE_IDENT: w_kernel[i] = COEF_W'($signed(IDENT_K[i]));
        default: begin
          if (wgt_wr_en && (wgt_addr == 4'(i))) w_kernel[i] = wgt_data;
        end
      endcase
    end
  end

  always_comb begin
    w_row_pix = r_win[0 +: 3*DATA_W];
    w_row_wgt = r_active[2:0];
    case (r_state)
      ST_ROW1: begin
        w_row_pix = r_win[3*DATA_W +: 3*DATA_W];
        w_row_wgt = r_active[5:3];
      end
      ST_ROW2: begin
        w_row_pix = r_win[6*DATA_W +: 3*DATA_W];
        w_row_wgt = r_active[8:6];
      end
      default: ;
    endcase
  end

  conv3_row_mac #(
    .DATA_W (DATA_W),
    .COEF_W (COEF_W),
    .ACC_W  (ACC_W)
  ) u_row_mac (
    .i_pix   (w_row_pix),
    .i_wgt   (w_row_wgt),
    .o_sum_c (w_row_sum)
  );

  assign w_final = r_acc + w_row_sum + ACC_W'(r_bias);
  assign w_fit   = sat_fit(FIT_W'(w_final), OUT_W, SAT_EN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow <= '0;
    end else begin
      for (int unsigned i = 0; i < NTAPS; i++) begin
        if (wgt_wr_en && (wgt_addr == 4'(i))) r_shadow[i] <= wgt_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_win     <= '0;
      r_bias    <= '0;
      r_active  <= '0;
      r_acc     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_win    <= in_win;
        r_bias   <= $signed(cfg_bias);
        r_active <= w_kernel;
      end
      case (r_state)
        ST_ROW0: r_acc <= w_row_sum;
        ST_ROW1: r_acc <= r_acc + w_row_sum;
        ST_ROW2: begin
          out_data  <= OUT_W'(w_fit);
          out_sat   <= w_fit[FIT_W];
          out_valid <= 1'b1;
        end
        ST_DONE: if (out_ready) out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule
